// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared defines for the byte-serial RAM port controller
package mem_ctrl_pkg;

  localparam int          RamAddrBus = 17;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic        RstEnable  = 1'b0;

  localparam logic [1:0] LenByte = 2'b00;
  localparam logic [1:0] LenHalf = 2'b01;
  localparam logic [1:0] LenWord = 2'b10;

  localparam logic OwnerIf  = 1'b0;
  localparam logic OwnerMem = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RD_IF  = 2'b01,
    RD_MEM = 2'b10,
    WR_MEM = 2'b11
  } state_e;

  // Code 11 is not a legal size and is served as a word.
  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      LenByte: return 3'd1;
      LenHalf: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - arbitrates the byte-wide RAM between fetch and load/store, one byte per cycle
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = RamAddrBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  input  logic              if_flush_i,
  output logic [31:0]       if_inst_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i,
  output logic              busy_o
);

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [2:0]        n_q;
  logic [2:0]        cnt_q;
  logic [31:0]       buf_q;
  logic [31:0]       wdata_q;
  logic              owner_q;
  logic              if_done_q;
  logic              mem_done_q;
  logic [31:0]       if_inst_q;
  logic [31:0]       mem_rdata_q;

  logic [ADDR_W-1:0] addr_cur;
  logic [31:0]       buf_d;
  logic              done_busy;

  assign addr_cur  = base_q + {{(ADDR_W-3){1'b0}}, cnt_q};
  assign done_busy = if_done_q | mem_done_q;

  // Read data lags the address by one cycle, so byte cnt-1 arrives while cnt is on the bus.
  always_comb begin
    buf_d = buf_q;
    case (cnt_q)
      3'd1:    buf_d[7:0]   = ram_din_i;
      3'd2:    buf_d[15:8]  = ram_din_i;
      3'd3:    buf_d[23:16] = ram_din_i;
      3'd4:    buf_d[31:24] = ram_din_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state_q     <= IDLE;
      base_q      <= '0;
      n_q         <= 3'd0;
      cnt_q       <= 3'd0;
      buf_q       <= ZeroWord;
      wdata_q     <= ZeroWord;
      owner_q     <= OwnerIf;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= ZeroWord;
      mem_rdata_q <= ZeroWord;
    end else begin
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= ZeroWord;
      mem_rdata_q <= ZeroWord;
      case (state_q)
        IDLE: begin
          // A requester still holding req during its done pulse must not be restarted.
          if (!done_busy) begin
            if (mem_req_i) begin
              base_q  <= mem_addr_i[ADDR_W-1:0];
              n_q     <= len_to_n(mem_len_i);
              wdata_q <= mem_wdata_i;
              cnt_q   <= 3'd0;
              buf_q   <= ZeroWord;
              owner_q <= OwnerMem;
              state_q <= mem_we_i ? WR_MEM : RD_MEM;
            end else if (if_req_i && !if_flush_i) begin
              base_q  <= if_addr_i[ADDR_W-1:0];
              n_q     <= 3'd4;
              cnt_q   <= 3'd0;
              buf_q   <= ZeroWord;
              owner_q <= OwnerIf;
              state_q <= RD_IF;
            end
          end
        end
        RD_IF, RD_MEM: begin
          if (state_q == RD_IF && if_flush_i) begin
            cnt_q   <= 3'd0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
            buf_q <= buf_d;
            if (cnt_q == n_q) begin
              cnt_q   <= 3'd0;
              state_q <= IDLE;
              if (owner_q == OwnerMem) begin
                mem_done_q  <= 1'b1;
                mem_rdata_q <= buf_d;
              end else begin
                if_done_q <= 1'b1;
                if_inst_q <= buf_d;
              end
            end
          end
        end
        WR_MEM: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == n_q - 3'd1) begin
            cnt_q      <= 3'd0;
            state_q    <= IDLE;
            mem_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    ram_a_o    = '0;
    ram_wr_o   = 1'b0;
    ram_dout_o = 8'h00;
    case (state_q)
      RD_IF, RD_MEM: ram_a_o = addr_cur;
      WR_MEM: begin
        ram_a_o    = addr_cur;
        ram_wr_o   = 1'b1;
        ram_dout_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign if_done_o   = if_done_q;
  assign if_inst_o   = if_inst_q;
  assign mem_done_o  = mem_done_q;
  assign mem_rdata_o = mem_rdata_q;

  generate
    if (ADDR_W < 32) begin : g_trunc
      logic unused_addr_hi;
      assign unused_addr_hi = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};
    end
  endgenerate

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl against a byte-array reference memory
module tb_mem_ctrl;

  localparam int AW    = 17;
  localparam int MSIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req_i = 1'b0;
  logic [31:0]   if_addr_i = '0;
  logic          if_flush_i = 1'b0;
  logic [31:0]   if_inst_o;
  logic          if_done_o;
  logic          mem_req_i = 1'b0;
  logic          mem_we_i = 1'b0;
  logic [1:0]    mem_len_i = '0;
  logic [31:0]   mem_addr_i = '0;
  logic [31:0]   mem_wdata_i = '0;
  logic [31:0]   mem_rdata_o;
  logic          mem_done_o;
  logic [AW-1:0] ram_a_o;
  logic [7:0]    ram_dout_o;
  logic          ram_wr_o;
  logic [7:0]    ram_din_i = '0;
  logic          busy_o;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] ram  [MSIZE];
  logic [7:0] refm [MSIZE];

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_inst_o(if_inst_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
    .ram_a_o(ram_a_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o),
    .ram_din_i(ram_din_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one cycle of read latency
  always @(posedge clk) begin
    ram_din_i <= ram[ram_a_o];
    if (ram_wr_o) ram[ram_a_o] <= ram_dout_o;
  end

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input int n);
    logic [31:0] v = '0;
    int a = int'(addr[AW-1:0]);
    for (int i = 0; i < n; i++) v |= 32'(refm[(a + i) % MSIZE]) << (8 * i);
    return v;
  endfunction

  function automatic void ref_store(input logic [31:0] addr, input int n, input logic [31:0] wd);
    int a = int'(addr[AW-1:0]);
    for (int i = 0; i < n; i++) refm[(a + i) % MSIZE] = wd[8*i +: 8];
  endfunction

  task automatic do_mem(input logic we, input logic [1:0] len, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic done_after);
    mem_we_i = we; mem_len_i = len; mem_addr_i = addr; mem_wdata_i = wd; mem_req_i = 1'b1;
    lat = -1; rd = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (mem_done_o) begin lat = k; rd = mem_rdata_o; break; end
    end
    mem_req_i = 1'b0;
    @(negedge clk);
    done_after = mem_done_o;
  endtask

  task automatic do_if(input logic [31:0] addr, output int lat, output logic [31:0] inst,
                       output logic done_after);
    if_addr_i = addr; if_flush_i = 1'b0; if_req_i = 1'b1;
    lat = -1; inst = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (if_done_o) begin lat = k; inst = if_inst_o; break; end
    end
    if_req_i = 1'b0;
    @(negedge clk);
    done_after = if_done_o;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({if_done_o, mem_done_o, ram_wr_o, busy_o} !== 4'b0 || if_inst_o !== 32'h0 ||
        mem_rdata_o !== 32'h0 || ram_a_o !== '0 || ram_dout_o !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs: got done=%b/%b wr=%b busy=%b a=%h dout=%h, want all 0",
               if_done_o, mem_done_o, ram_wr_o, busy_o, ram_a_o, ram_dout_o);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_fetch();
    int first = -1;
    if_addr_i = 32'h100; if_flush_i = 1'b0; if_req_i = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        vectors++;
        if (ram_a_o !== AW'(32'h100 + k - 1) || ram_wr_o !== 1'b0) begin
          errors++;
          $display("FAIL fetch_addr C%0d: got a=%h wr=%b want a=%h wr=0", k, ram_a_o, ram_wr_o,
                   AW'(32'h100 + k - 1));
        end
      end
      if (if_done_o && first < 0) begin
        first = k;
        vectors++;
        if (if_inst_o !== ref_load(32'h100, 4) || if_inst_o !== 32'h00100513) begin
          errors++; $display("FAIL fetch_data: got %h want %h", if_inst_o, ref_load(32'h100, 4));
        end
        if_req_i = 1'b0;
      end
    end
    vectors++;
    if (first != 6) begin errors++; $display("FAIL fetch_latency: got C%0d want C6", first); end
    vectors++;
    if (if_done_o !== 1'b0) begin errors++; $display("FAIL fetch_pulse: done=%b in C7 want 0", if_done_o); end
    if_req_i = 1'b0;
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic da;
    logic [31:0] wd = 32'hDEADBEEF;
    mem_we_i = 1'b1; mem_len_i = 2'b10; mem_addr_i = 32'h200; mem_wdata_i = wd; mem_req_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        vectors++;
        if (ram_wr_o !== 1'b1 || ram_a_o !== AW'(32'h200 + k - 1) || ram_dout_o !== wd[8*(k-1) +: 8]) begin
          errors++;
          $display("FAIL store_byte C%0d: got wr=%b a=%h d=%h want wr=1 a=%h d=%h", k, ram_wr_o,
                   ram_a_o, ram_dout_o, AW'(32'h200 + k - 1), wd[8*(k-1) +: 8]);
        end
      end
      vectors++;
      if (mem_done_o !== (k == 5)) begin
        errors++; $display("FAIL store_done C%0d: got %b want %b", k, mem_done_o, k == 5);
      end
    end
    mem_req_i = 1'b0;
    @(negedge clk);
    ref_store(32'h200, 4, wd);
    do_mem(1'b0, 2'b01, 32'h202, 32'h0, lat, rd, da);
    vectors++;
    if (lat != 4 || rd !== ref_load(32'h202, 2) || rd !== 32'h0000DEAD) begin
      errors++; $display("FAIL half_load: got lat=%0d rd=%h want lat=4 rd=0000dead", lat, rd);
    end
  endtask

  task automatic test_priority();
    int kmem = -1, kif = -1;
    logic [31:0] rd = '0, inst = '0;
    if_addr_i = 32'h100; if_flush_i = 1'b0; if_req_i = 1'b1;
    mem_we_i = 1'b0; mem_len_i = 2'b00; mem_addr_i = 32'h200; mem_req_i = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_done_o && kmem < 0) begin kmem = k; rd = mem_rdata_o; mem_req_i = 1'b0; end
      if (if_done_o) begin kif = k; inst = if_inst_o; break; end
    end
    if_req_i = 1'b0; mem_req_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (kmem != 3 || rd !== ref_load(32'h200, 1)) begin
      errors++; $display("FAIL prio_mem: got C%0d rd=%h want C3 rd=%h", kmem, rd, ref_load(32'h200, 1));
    end
    vectors++;
    if (kif != 10 || inst !== ref_load(32'h100, 4)) begin
      errors++; $display("FAIL prio_if: got C%0d inst=%h want C10 inst=%h", kif, inst, ref_load(32'h100, 4));
    end
  endtask

  task automatic test_flush();
    int seen = 0, lat; logic [31:0] inst; logic da;
    if_addr_i = 32'h100; if_flush_i = 1'b0; if_req_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (if_done_o) seen++;
      if (k == 3) begin if_flush_i = 1'b1; if_addr_i = 32'h104; end
      if (k == 4) begin
        vectors++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_idle: busy=%b want 0", busy_o); end
      end
    end
    if_flush_i = 1'b0; if_req_i = 1'b0;
    do_if(32'h104, lat, inst, da);
    vectors++;
    if (seen != 0) begin errors++; $display("FAIL flush_nodone: got %0d done pulses want 0", seen); end
    vectors++;
    if (lat != 6 || inst !== ref_load(32'h104, 4)) begin
      errors++; $display("FAIL flush_refetch: got lat=%0d inst=%h want 6 %h", lat, inst, ref_load(32'h104, 4));
    end
  endtask

  task automatic test_reset_mid_store();
    int seen = 0, lat; logic [31:0] rd; logic da;
    mem_we_i = 1'b1; mem_len_i = 2'b10; mem_addr_i = 32'h300; mem_wdata_i = 32'h11223344; mem_req_i = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (ram_wr_o !== 1'b1) begin errors++; $display("FAIL rst_pre: wr=%b want 1", ram_wr_o); end
    rst = 1'b0;
    #1;
    vectors++;
    if (ram_wr_o !== 1'b0 || busy_o !== 1'b0 || ram_a_o !== '0 || ram_dout_o !== 8'h0) begin
      errors++; $display("FAIL rst_async: got wr=%b busy=%b a=%h d=%h want 0", ram_wr_o, busy_o, ram_a_o, ram_dout_o);
    end
    mem_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin @(negedge clk); if (mem_done_o) seen++; end
    vectors++;
    if (seen != 0) begin errors++; $display("FAIL rst_nodone: got %0d pulses want 0", seen); end
    ref_store(32'h300, 2, 32'h11223344);
    do_mem(1'b0, 2'b10, 32'h300, 32'h0, lat, rd, da);
    vectors++;
    if (lat != 6 || rd !== ref_load(32'h300, 4)) begin
      errors++; $display("FAIL rst_partial: got lat=%0d rd=%h want 6 %h", lat, rd, ref_load(32'h300, 4));
    end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rd; logic da;
    logic [31:0] wd = $urandom;
    do_mem(1'b1, 2'b10, 32'h0001FFFF, wd, lat, rd, da);
    ref_store(32'h0001FFFF, 4, wd);
    vectors++;
    if (lat != 5) begin errors++; $display("FAIL wrap_store: lat=%0d want 5", lat); end
    mem_we_i = 1'b0; mem_len_i = 2'b10; mem_addr_i = 32'h0001FFFF; mem_req_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        vectors++;
        if (ram_a_o !== AW'((32'h1FFFF + k - 1) % MSIZE)) begin
          errors++; $display("FAIL wrap_addr C%0d: got %h want %h", k, ram_a_o, AW'((32'h1FFFF + k - 1) % MSIZE));
        end
      end
      if (k == 6) begin
        vectors++;
        if (mem_done_o !== 1'b1 || mem_rdata_o !== ref_load(32'h0001FFFF, 4)) begin
          errors++; $display("FAIL wrap_load: got done=%b rd=%h want 1 %h", mem_done_o, mem_rdata_o, ref_load(32'h0001FFFF, 4));
        end
      end
    end
    mem_req_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, n; logic [31:0] rd, addr, wd; logic [1:0] len; logic we, da;
    for (int it = 0; it < 60; it++) begin
      we   = 1'($urandom_range(0, 1));
      len  = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 3) == 0) ? (32'h0001FFFC + $urandom_range(0, 3)) : $urandom;
      wd   = $urandom;
      n    = nbytes(len);
      do_mem(we, len, addr, wd, lat, rd, da);
      vectors++;
      if (we) begin
        ref_store(addr, n, wd);
        if (lat != n + 1 || da !== 1'b0) begin
          errors++; $display("FAIL rand_store %0d: lat=%0d after=%b want %0d 0", it, lat, da, n + 1);
        end
      end else if (lat != n + 2 || rd !== ref_load(addr, n) || da !== 1'b0) begin
        errors++; $display("FAIL rand_load %0d: lat=%0d rd=%h after=%b want %0d %h 0", it, lat, rd, da, n + 2, ref_load(addr, n));
      end
      if ($urandom_range(0, 3) == 0) begin
        addr = $urandom;
        do_if(addr, lat, rd, da);
        vectors++;
        if (lat != 6 || rd !== ref_load(addr, 4) || da !== 1'b0) begin
          errors++; $display("FAIL rand_fetch %0d: lat=%0d inst=%h want 6 %h", it, lat, rd, ref_load(addr, 4));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MSIZE; i++) begin
      ram[i]  = 8'((i * 7 + 3) ^ (i >> 8));
      refm[i] = 8'((i * 7 + 3) ^ (i >> 8));
    end
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
    refm[32'h100] = 8'h13; refm[32'h101] = 8'h05; refm[32'h102] = 8'h10; refm[32'h103] = 8'h00;
    test_reset();
    test_fetch();
    @(negedge clk);
    test_store_load();
    test_priority();
    test_flush();
    test_reset_mid_store();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
